lms_serial_core: RTL and testbench
==================================

LMS_SERIAL_CORE -- requirements
Module: lms_serial_core

Interface
REQ-001 SHALL have parameter N, default 8, meaning tap count (positive integer).
REQ-002 SHALL have parameter W, default 16, meaning signed sample width in bits.
REQ-003 SHALL have parameter WW, default 16, meaning signed weight width, Q1.(WW-1).
REQ-004 SHALL have parameter MU_SHIFT, default 8, meaning step size as a right shift (mu = 2^-MU_SHIFT).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: request one filter-and-adapt iteration.
REQ-008 SHALL have port upd_en, input, 1 bit: 1 = adapt weights this iteration, 0 = weights frozen.
REQ-009 SHALL have port x_all, input, W*N bits: tap vector, with tap i = x_all[W*i +: W] (tap 0 newest).
REQ-010 SHALL have port d, input, W bits: desired sample.
REQ-011 SHALL have port y, output, W bits: filter output.
REQ-012 SHALL have port e, output, W bits: error d - y.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse marking y and e as valid.
REQ-014 SHALL have port busy, output, 1 bit: high while an iteration is in progress.
REQ-015 SHALL have port w_all, output, WW*N bits: current weights, with w_i = w_all[WW*i +: WW].

Function
REQ-016 SHALL use FSM states IDLE, FILT, ERR, UPD and DONE; busy = (state != IDLE).
REQ-017 SHALL accept start only in IDLE, latching x_all, d and upd_en on the accepting cycle t; start in any other state is ignored, not queued.
REQ-018 SHALL hold FILT for cycles t+1..t+N, one MAC per cycle over i = 0..N-1: acc += x_i*w_i, with acc cleared at entry and of width W+WW+clog2(N).
REQ-019 SHALL in ERR (cycle t+N+1) form y = acc >>> (WW-1) reduced to W bits, and e = d - y computed in W+1 bits then reduced to W bits.
REQ-020 SHALL, when latched upd_en = 1, hold UPD for cycles t+N+2..t+2N+1, one tap per cycle: w_i += ((e*x_i) >>> (W-1+MU_SHIFT)) reduced to WW bits.
REQ-021 SHALL, when latched upd_en = 0, go from ERR directly to DONE, leaving the weights untouched.
REQ-022 SHALL assert done for exactly one cycle in DONE (t+2N+2 when adapting, t+N+2 when frozen), then return to IDLE.
REQ-023 SHALL hold y and e stable from the ERR update until the next ERR.
REQ-024 SHALL ignore a start arriving in the DONE cycle; a start in the following IDLE cycle is accepted.
REQ-025 SHALL use the single shared multiplier in both FILT and UPD, one product per cycle.

Reset
REQ-026 SHALL, on rst, force state IDLE, y=0, e=0, done=0, busy=0, every weight to 0 and acc=0, overriding start.
REQ-027 SHALL abort any iteration when rst arrives mid-operation (any state), with no done pulse and no partial weight write surviving.

Configuration
REQ-028 SHALL, with macro LMS_SAT_EN defined, saturate every width reduction (y, e, each weight) to the signed min/max of the target width.
REQ-029 SHALL, without LMS_SAT_EN, reduce all widths by two's-complement truncation (wrap).

Structure
REQ-030 SHALL place the FSM state enum, the accumulator-width constant function and the saturate/truncate helper function in shared package lms_pkg.
REQ-031 SHALL implement the multiply, accumulate and reduce datapath as sub-module lms_mac, instantiated once.

Verification (N=4, W=16, WW=16, MU_SHIFT=4)
REQ-032 SHALL cover: after rst, start with x_i=0x1000 all taps, d=0x0800, upd_en=1 -> y=0, e=0x0800, done at t+10, every w_i=0x0010.
REQ-033 SHALL cover: the same stimulus with upd_en=0 -> done at t+6, w_all unchanged.
REQ-034 SHALL cover: start held high through an entire iteration -> exactly one iteration per IDLE visit, with the start in the DONE cycle ignored.
REQ-035 SHALL cover: weights at 0x0010, x_i=0x8000, d=0x7FFF -> y=0xFFC0; e=0x7FFF with LMS_SAT_EN, e=0x803F without it.
REQ-036 SHALL cover: rst asserted at the second UPD cycle -> the next cycle has busy=0, w_all=0, and no done pulse.

Source files
------------

// File: rtl/lms_pkg.sv
// Shared types and helpers for the serial LMS core.
// Define LMS_SAT_EN to saturate width reductions instead of wrapping.
package lms_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILT,
        ERR,
        UPD,
        DONE
    } state_t;

`ifdef LMS_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    function automatic int lms_acc_w(input int n, input int w, input int ww);
        return w + ww + $clog2(n);
    endfunction

    // Result is sign-extended to 64 bits; callers keep the low width bits.
    function automatic logic signed [63:0] lms_reduce(
        input logic signed [63:0] v,
        input int                 width
    );
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        logic signed [63:0] r;
        mx = (64'sd1 <<< (width - 1)) - 64'sd1;
        mn = -mx - 64'sd1;
        if (SAT_EN) begin
            if (v > mx) begin
                r = mx;
            end else if (v < mn) begin
                r = mn;
            end else begin
                r = v;
            end
        end else begin
            r = v <<< (64 - width);
            r = r >>> (64 - width);
        end
        return r;
    endfunction

endpackage

// File: rtl/lms_mac.sv
// Shared multiplier, accumulator and width-reduction datapath
// for the serial LMS core (saturation selected by LMS_SAT_EN).
module lms_mac
    import lms_pkg::*;
#(
    parameter int W        = 16,
    parameter int WW       = 16,
    parameter int BW       = 16,
    parameter int AW       = 34,
    parameter int MU_SHIFT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [W-1:0]  a,
    input  logic signed [BW-1:0] b,
    input  logic signed [WW-1:0] w_cur,
    input  logic signed [W-1:0]  d,
    output logic signed [W-1:0]  y_new,
    output logic signed [W-1:0]  e_new,
    output logic signed [WW-1:0] w_new
);

    localparam int PW = W + BW;

    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_d;

    always_comb begin
        prod  = PW'(a) * PW'(b);
        acc_d = acc_q + AW'(prod);
        y_new = W'(lms_reduce(64'(acc_q >>> (WW - 1)), W));
        e_new = W'(lms_reduce(64'(d) - 64'(y_new), W));
        // In UPD the same product is e * x_i.
        w_new = WW'(lms_reduce(
            64'(w_cur) + (64'(prod) >>> (W - 1 + MU_SHIFT)), WW));
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/lms_serial_core.sv
// Serial LMS adaptive FIR: one MAC per cycle for filter and update.
// Define LMS_SAT_EN for saturating reductions (default wraps).
module lms_serial_core
    import lms_pkg::*;
#(
    parameter int N        = 8,
    parameter int W        = 16,
    parameter int WW       = 16,
    parameter int MU_SHIFT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            upd_en,
    input  logic [W*N-1:0]  x_all,
    input  logic [W-1:0]    d,
    output logic [W-1:0]    y,
    output logic [W-1:0]    e,
    output logic            done,
    output logic            busy,
    output logic [WW*N-1:0] w_all
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = (W > WW) ? W : WW;
    localparam int AW = lms_acc_w(N, W, WW);

    state_t               state_q;
    logic [IW-1:0]        idx_q;
    logic                 upd_q;
    logic                 done_q;
    logic                 busy_q;
    logic signed [W-1:0]  x_q [N];
    logic signed [W-1:0]  d_q;
    logic signed [W-1:0]  y_q;
    logic signed [W-1:0]  e_q;
    logic signed [WW-1:0] w_q [N];

    logic signed [W-1:0]  a_mux;
    logic signed [BW-1:0] b_mux;
    logic signed [W-1:0]  y_new;
    logic signed [W-1:0]  e_new;
    logic signed [WW-1:0] w_new;
    logic                 clr;
    logic                 mac_en;
    logic                 last;

    always_comb begin
        a_mux  = x_q[idx_q];
        b_mux  = (state_q == UPD) ? BW'(e_q) : BW'(w_q[idx_q]);
        clr    = (state_q == IDLE);
        mac_en = (state_q == FILT);
        last   = (idx_q == IW'(N - 1));
    end

    lms_mac #(
        .W       (W),
        .WW      (WW),
        .BW      (BW),
        .AW      (AW),
        .MU_SHIFT(MU_SHIFT)
    ) u_mac (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (mac_en),
        .a    (a_mux),
        .b    (b_mux),
        .w_cur(w_q[idx_q]),
        .d    (d_q),
        .y_new(y_new),
        .e_new(e_new),
        .w_new(w_new)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            upd_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            d_q     <= '0;
            y_q     <= '0;
            e_q     <= '0;
            for (int i = 0; i < N; i++) begin
                x_q[i] <= '0;
                w_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            x_q[i] <= x_all[W*i +: W];
                        end
                        d_q     <= d;
                        upd_q   <= upd_en;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= FILT;
                    end
                end
                FILT: begin
                    idx_q <= last ? '0 : idx_q + IW'(1);
                    if (last) begin
                        state_q <= ERR;
                    end
                end
                ERR: begin
                    y_q <= y_new;
                    e_q <= e_new;
                    if (upd_q) begin
                        state_q <= UPD;
                    end else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                UPD: begin
                    w_q[idx_q] <= w_new;
                    idx_q      <= last ? '0 : idx_q + IW'(1);
                    if (last) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_w
        assign w_all[WW*gi +: WW] = w_q[gi];
    end

    assign y    = y_q;
    assign e    = e_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_lms_serial_core.sv
// Scoreboard bench for lms_serial_core with an arithmetic LMS model.
// Honours LMS_SAT_EN the same way as the design.
module tb_lms_serial_core;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int WW = 16;
    localparam int MU = 4;
`ifdef LMS_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            upd_en;
    logic [W*N-1:0]  x_all;
    logic [W-1:0]    d;
    logic [W-1:0]    y;
    logic [W-1:0]    e;
    logic            done;
    logic            busy;
    logic [WW*N-1:0] w_all;

    always #5 clk = ~clk;

    lms_serial_core #(
        .N       (N),
        .W       (W),
        .WW      (WW),
        .MU_SHIFT(MU)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .upd_en(upd_en),
        .x_all (x_all),
        .d     (d),
        .y     (y),
        .e     (e),
        .done  (done),
        .busy  (busy),
        .w_all (w_all)
    );

    typedef struct {
        int          t;
        int          lat;
        logic [15:0] y;
        logic [15:0] e;
        logic [63:0] w;
    } exp_t;

    exp_t   sb[$];
    longint wm[N];
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    int     ndone = 0;
    logic   done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint red(longint v, int width);
        longint lim;
        longint m;
        lim = longint'(1) << (width - 1);
        if (SAT) begin
            if (v > lim - 1) return lim - 1;
            if (v < -lim) return -lim;
            return v;
        end
        m = v & ((lim << 1) - 1);
        return (m >= lim) ? m - (lim << 1) : m;
    endfunction

    function automatic logic [63:0] pack_w();
        logic [63:0] p;
        for (int i = 0; i < N; i++) p[16*i +: 16] = 16'(wm[i]);
        return p;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp_v);
        end
    endtask

    task automatic model_push(int t, logic [63:0] xv, logic [15:0] dv,
                              logic u);
        longint acc;
        longint xs[N];
        longint yv;
        longint ev;
        exp_t   ex;
        acc = 0;
        for (int i = 0; i < N; i++) begin
            xs[i] = longint'($signed(xv[16*i +: 16]));
            acc = acc + xs[i] * wm[i];
        end
        yv = red(acc >>> (WW - 1), W);
        ev = red(longint'($signed(dv)) - yv, W);
        if (u) begin
            for (int i = 0; i < N; i++)
                wm[i] = red(wm[i] + ((ev * xs[i]) >>> (W - 1 + MU)), WW);
        end
        ex.t   = t;
        ex.lat = u ? 2 * N + 2 : N + 2;
        ex.y   = 16'(yv);
        ex.e   = 16'(ev);
        ex.w   = pack_w();
        sb.push_back(ex);
    endtask

    always begin
        exp_t ex;
        @(posedge clk);
        #1;
        if (done) begin
            chk("done_width", 64'(done_prev), 64'(0));
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                ex = sb.pop_front();
                chk("y", 64'(y), 64'(ex.y));
                chk("e", 64'(e), 64'(ex.e));
                chk("w_all", w_all, ex.w);
                chk("latency", 64'(cyc - ex.t), 64'(ex.lat));
                ndone++;
            end
        end
        done_prev = done;
    end

    task automatic wait_done(int target);
        for (int c = 0; c < 80 && ndone < target; c++) @(negedge clk);
        chk("done_timeout", 64'(ndone >= target), 64'(1));
        @(negedge clk);
    endtask

    task automatic issue(logic [63:0] xv, logic [15:0] dv, logic u);
        int tgt;
        tgt    = ndone + 1;
        start  = 1'b1;
        x_all  = xv;
        d      = dv;
        upd_en = u;
        model_push(cyc, xv, dv, u);
        @(negedge clk);
        start  = 1'b0;
        x_all  = {$urandom, $urandom};
        d      = 16'($urandom);
        upd_en = 1'($urandom);
        wait_done(tgt);
    endtask

    initial begin
        int t0;
        int tgt;
        rst    = 1'b1;
        start  = 1'b1;
        upd_en = 1'b1;
        x_all  = '1;
        d      = '1;
        for (int i = 0; i < N; i++) wm[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_y", 64'(y), 64'(0));
        chk("rst_e", 64'(e), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_w", w_all, 64'(0));
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        issue({4{16'h1000}}, 16'h0800, 1'b1);
        chk("adapt_w", w_all, {4{16'h0010}});
        chk("hold_y", 64'(y), 64'(0));
        chk("hold_e", 64'(e), 64'(16'h0800));
        chk("idle_busy", 64'(busy), 64'(0));

        issue({4{16'h1000}}, 16'h0800, 1'b0);
        chk("frozen_w", w_all, {4{16'h0010}});

        issue({4{16'h8000}}, 16'h7FFF, 1'b0);
        chk("neg_y", 64'(y), 64'(16'hFFC0));
        chk("red_e", 64'(e), SAT ? 64'(16'h7FFF) : 64'(16'h803F));

        t0     = cyc;
        tgt    = ndone + 2;
        start  = 1'b1;
        x_all  = {4{16'h0400}};
        d      = 16'h0100;
        upd_en = 1'b1;
        model_push(t0, x_all, d, 1'b1);
        repeat (2 * N + 3) @(negedge clk);
        model_push(cyc, x_all, d, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_done(tgt);
        repeat (5) @(negedge clk);
        chk("held_queue", 64'(sb.size()), 64'(0));
        chk("held_busy", 64'(busy), 64'(0));

        for (int k = 0; k < 20; k++)
            issue({$urandom, $urandom}, 16'($urandom), 1'($urandom));

        start  = 1'b1;
        x_all  = {4{16'h1000}};
        d      = 16'h0800;
        upd_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (N + 2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_w", w_all, 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_y", 64'(y), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) wm[i] = 0;
        repeat (20) @(negedge clk);
        chk("abort_queue", 64'(sb.size()), 64'(0));
        chk("abort_idle", 64'(busy), 64'(0));
        chk("abort_w_idle", w_all, 64'(0));

        issue({4{16'h1000}}, 16'h0800, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
